list_sum_ctrl: RTL and testbench

LIST_SUM_CTRL -- requirements
Module: list_sum_ctrl

---
 rtl/list_sum_ctrl.sv | 112 +++++++++++
 tb/tb_list_sum_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/list_sum_ctrl.sv
// list_sum_ctrl
//   Collects up to LENGTH elements into a zero-padded packed buffer. It then
//   presents the buffer to an external adder. When the adder reports done,
//   it captures the sum together with the element count and holds that
//   result for a downstream consumer.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     element handshake; in_data carries the value and
//                         in_last closes the list early
//   data_out              packed list buffer that feeds the adder
//   sum_en                sum request, high while waiting on the adder
//   sum_result/sum_done   adder result and its valid strobe
//   res_valid/res_ready   result handshake; res_data is the captured sum and
//                         res_count is the number of elements in that list
module list_sum_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int LENGTH     = 8,
  localparam int LENGTH_WIDTH = $clog2(LENGTH),
  localparam int CNT_WIDTH    = $clog2(LENGTH + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DATA_WIDTH-1:0]                in_data,
  input  logic                                 in_last,
  output logic [LENGTH-1:0][DATA_WIDTH-1:0]    data_out,
  output logic                                 sum_en,
  input  logic [LENGTH_WIDTH+DATA_WIDTH-1:0]   sum_result,
  input  logic                                 sum_done,
  output logic                                 res_valid,
  input  logic                                 res_ready,
  output logic [LENGTH_WIDTH+DATA_WIDTH-1:0]   res_data,
  output logic [CNT_WIDTH-1:0]                 res_count
);

  localparam int SUM_WIDTH = LENGTH_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {
    FILL,
    SUM,
    HOLD
  } state_e;

  state_e                              state_q, state_d;
  logic [CNT_WIDTH-1:0]                cnt_q, cnt_d;
  logic [LENGTH-1:0][DATA_WIDTH-1:0]   buf_q, buf_d;
  logic [SUM_WIDTH-1:0]                res_data_q, res_data_d;
  logic [CNT_WIDTH-1:0]                res_count_q, res_count_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    res_data_d  = res_data_q;
    res_count_d = res_count_q;

    unique case (state_q)
      FILL: begin
        if (in_valid) begin
          // The write slot is selected by comparison so that the index does
          // not depend on CNT_WIDTH matching the slot-index width.
          for (int unsigned i = 0; i < LENGTH; i++) begin
            if (cnt_q == CNT_WIDTH'(i)) buf_d[i] = in_data;
          end
          cnt_d = cnt_q + 1'b1;
          if (in_last || (cnt_q == CNT_WIDTH'(LENGTH - 1))) state_d = SUM;
        end
      end
      SUM: begin
        if (sum_done) begin
          res_data_d  = sum_result;
          res_count_d = cnt_q;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      buf_q       <= '0;
      res_data_q  <= '0;
      res_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      res_data_q  <= res_data_d;
      res_count_q <= res_count_d;
    end
  end

  assign in_ready  = (state_q == FILL);
  assign sum_en    = (state_q == SUM);
  assign res_valid = (state_q == HOLD);
  assign data_out  = buf_q;
  assign res_data  = res_data_q;
  assign res_count = res_count_q;

endmodule

// File: tb/tb_list_sum_ctrl.sv
// Self-checking bench for list_sum_ctrl (DATA_WIDTH=32, LENGTH=8).
// A list-level model is kept in a queue. An adder model with a selectable
// delay drives sum_result/sum_done. Every cycle, all outputs are compared
// against the model, and directed scenarios add literal expectations.
module tb_list_sum_ctrl;
  localparam int DW  = 32;
  localparam int LEN = 8;
  localparam int SW  = 35;
  localparam int CW  = 4;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_last, sum_en, sum_done, res_valid, res_ready;
  logic [DW-1:0] in_data;
  logic [LEN-1:0][DW-1:0] data_out;
  logic [SW-1:0] sum_result, res_data;
  logic [CW-1:0] res_count;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [DW-1:0] m_list[$];
  bit            m_summing, m_holding;
  logic [SW-1:0] m_res_data;
  int unsigned   m_res_count;

  int unsigned adder_delay, sum_age;

  always #5 clk = ~clk;

  list_sum_ctrl #(.DATA_WIDTH(DW), .LENGTH(LEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .data_out(data_out),
    .sum_en(sum_en), .sum_result(sum_result), .sum_done(sum_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_count(res_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_list.delete();
    m_summing   = 1'b0;
    m_holding   = 1'b0;
    m_res_data  = '0;
    m_res_count = 0;
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
    end else if (m_holding) begin
      if (res_ready) begin
        m_holding = 1'b0;
        m_list.delete();
      end
    end else if (m_summing) begin
      if (sum_done) begin
        m_res_data = '0;
        foreach (m_list[i]) m_res_data += SW'(m_list[i]);
        m_res_count = m_list.size();
        m_summing   = 1'b0;
        m_holding   = 1'b1;
      end
    end else if (in_valid) begin
      m_list.push_back(in_data);
      if (m_list.size() == LEN || in_last) m_summing = 1'b1;
    end
  endtask

  task automatic check_outputs();
    logic [DW-1:0] exp_slot;
    chk("in_ready", 64'(in_ready), 64'(!m_summing && !m_holding));
    chk("sum_en", 64'(sum_en), 64'(m_summing));
    chk("res_valid", 64'(res_valid), 64'(m_holding));
    chk("res_data", 64'(res_data), 64'(m_res_data));
    chk("res_count", 64'(res_count), 64'(m_res_count));
    for (int i = 0; i < LEN; i++) begin
      exp_slot = (i < m_list.size()) ? m_list[i] : '0;
      chk($sformatf("data_out[%0d]", i), 64'(data_out[i]), 64'(exp_slot));
    end
  endtask

  // One cycle: check at the negedge, drive the adder, advance the model on the posedge.
  task automatic tick();
    logic [SW-1:0] acc;
    logic [63:0]   r;
    check_outputs();
    if (sum_en) begin
      acc = '0;
      for (int i = 0; i < LEN; i++) acc += SW'(data_out[i]);
      sum_result = acc;
      sum_done   = (sum_age >= adder_delay);
      sum_age++;
    end else begin
      sum_age    = 0;
      r          = {$urandom(), $urandom()};
      sum_result = r[SW-1:0];
      sum_done   = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic send(input logic [DW-1:0] d, input bit last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_res(output int unsigned en_cycles);
    int unsigned n;
    n = 0;
    en_cycles = 0;
    while (!res_valid && n < 50) begin
      if (sum_en) en_cycles++;
      tick();
      n++;
    end
    chk("res_valid_wait", 64'(res_valid), 64'd1);
  endtask

  task automatic release_res();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    int unsigned en;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; res_ready = 1'b0;
    sum_done = 1'b0; sum_result = '0; adder_delay = 0; sum_age = 0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_sum_en", 64'(sum_en), 64'd0);
    chk("reset_res_valid", 64'(res_valid), 64'd0);
    chk("reset_res_data", 64'(res_data), 64'd0);
    chk("reset_res_count", 64'(res_count), 64'd0);
    chk("reset_data_out_lo", 64'(data_out[0]), 64'd0);

    // Full list 1..8
    for (int d = 1; d <= 8; d++) send(DW'(d), 1'b0);
    wait_res(en);
    chk("full_sum_en_cycles", 64'(en), 64'd1);
    chk("full_res_data", 64'(res_data), 64'd36);
    chk("full_model_res", 64'(m_res_data), 64'd36);
    chk("full_res_count", 64'(res_count), 64'd8);
    chk("full_data_out7", 64'(data_out[7]), 64'd8);
    release_res();

    // Early close 10,20,30
    send(32'd10, 1'b0);
    send(32'd20, 1'b0);
    send(32'd30, 1'b1);
    for (int i = 3; i < LEN; i++) chk("early_zero_slot", 64'(data_out[i]), 64'd0);
    wait_res(en);
    chk("early_res_data", 64'(res_data), 64'd60);
    chk("early_res_count", 64'(res_count), 64'd3);
    release_res();

    // Width: eight all-ones elements, then backpressure
    for (int i = 0; i < LEN; i++) send(32'hFFFF_FFFF, 1'b0);
    wait_res(en);
    chk("width_res_data", 64'(res_data), 64'h7_FFFF_FFF8);
    chk("width_res_count", 64'(res_count), 64'd8);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = $urandom();
      tick();
      chk("bp_res_valid", 64'(res_valid), 64'd1);
      chk("bp_res_data", 64'(res_data), 64'h7_FFFF_FFF8);
      chk("bp_res_count", 64'(res_count), 64'd8);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    release_res();

    // Slow adder: done arrives on the fourth SUM cycle
    adder_delay = 3;
    send(32'd100, 1'b0);
    send(32'd200, 1'b0);
    send(32'd300, 1'b0);
    send(32'd5, 1'b1);
    wait_res(en);
    chk("slow_sum_en_cycles", 64'(en), 64'd4);
    chk("slow_res_data", 64'(res_data), 64'd605);
    chk("slow_res_count", 64'(res_count), 64'd4);
    adder_delay = 0;
    release_res();

    // Reset mid-fill
    send(32'd5, 1'b0);
    send(32'd6, 1'b0);
    send(32'd7, 1'b0);
    send(32'd8, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    chk("rst_mid_slot0", 64'(data_out[0]), 64'd0);
    chk("rst_mid_slot3", 64'(data_out[3]), 64'd0);
    chk("rst_mid_res_data", 64'(res_data), 64'd0);
    chk("rst_mid_res_count", 64'(res_count), 64'd0);
    send(32'd1, 1'b0);
    send(32'd2, 1'b1);
    wait_res(en);
    chk("rst_mid_res_sum", 64'(res_data), 64'd3);
    chk("rst_mid_res_cnt", 64'(res_count), 64'd2);
    release_res();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 60) == 0);
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = ($urandom_range(0, 1) == 1) ? $urandom() : DW'($urandom_range(0, 15));
      in_last   = ($urandom_range(0, 3) == 0);
      res_ready = ($urandom_range(0, 2) == 0);
      if (!sum_en) adder_delay = $urandom_range(0, 4);
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; res_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
